mem_arbiter_rr: RTL
===================

// Module: mem_arbiter_rr
// PURPOSE
//   Parametrised N-channel arbiter that merges the processor's memory request ports onto one
//   memory port. All ports use the core's read/write/resp handshake. Typical use: separate
//   I-side and D-side requesters sharing one memory model. The block latches the granted request,
//   so a channel changing its signals mid-transaction does not disturb the memory side.
// PARAMETERS
//   NUM_CH    2   number of requester channels (>=2)
//   ADDR_W    32  address width
//   DATA_W    32  data width (multiple of 8); BE_W = DATA_W/8
//   ARB_MODE  0   0 = round-robin, 1 = fixed priority (lowest index wins)
// PORTS
//   clk              in   1              clock, all state on rising edge
//   rst_n            in   1              asynchronous, active-low reset
//   ch_read          in   NUM_CH         per-channel read request
//   ch_write         in   NUM_CH         per-channel write request
//   ch_address       in   NUM_CH*ADDR_W  per-channel address, channel i at [i*ADDR_W +: ADDR_W]
//   ch_wdata         in   NUM_CH*DATA_W  per-channel write data
//   ch_byte_enable   in   NUM_CH*BE_W    per-channel byte enables
//   ch_resp          out  NUM_CH         one-cycle completion pulse to the granted channel
//   ch_rdata         out  DATA_W         read data, shared, valid while ch_resp[g]=1
//   mem_read         out  1              memory read request
//   mem_write        out  1              memory write request
//   mem_address      out  ADDR_W         latched address of the granted request
//   mem_wdata        out  DATA_W         latched write data of the granted request
//   mem_byte_enable  out  BE_W           latched byte enables; 0 on reads
//   mem_resp         in   1              memory completion pulse
//   mem_rdata        in   DATA_W         memory read data, valid with mem_resp
//   busy             out  1              1 in any state other than IDLE
//   grant_id         out  clog2(NUM_CH)  index of the channel most recently granted
// BEHAVIOUR
//   Reset:
//   - Every output is 0. State = IDLE. rr_ptr = NUM_CH-1, so channel 0 wins first.
//   - Asserting rst_n=0 in any state aborts the transaction at once. An in-flight channel gets
//     no ch_resp.
//   Requester rule: a channel holds read/write asserted until it samples ch_resp=1, then
//   deasserts in the next cycle.
//   Request qualification:
//   - req[i] = ch_read[i] | ch_write[i].
//   - If both are set, the request is a write.
//   FSM (states IDLE, BUSY, RESP):
//   - IDLE: if any req[i], choose winner g. The next edge latches the channel-g fields into
//     mem_* and sets mem_read or mem_write. It also sets grant_id=g and goes to BUSY.
//     With no requests, stay in IDLE.
//   - BUSY: hold mem_* stable. When mem_resp=1, the next edge does the following: clear
//     mem_read/mem_write, capture ch_rdata=mem_rdata (writes also capture), set ch_resp[g]=1,
//     go to RESP.
//   - RESP: ch_resp[g]=1 for exactly this cycle; the next edge clears it and goes to IDLE.
//     ch_rdata holds its value until the next capture.
//   Latency: request seen in cycle 0 -> mem request from cycle 1. mem_resp in cycle t ->
//   ch_resp in cycle t+1. Back-to-back grants are separated by at least one IDLE cycle.
//   Arbitration:
//   - ARB_MODE=0: search indices rr_ptr+1 .. rr_ptr+NUM_CH, modulo NUM_CH; the first requester
//     wins. On grant, rr_ptr=g. A channel waits at most NUM_CH-1 grants.
//   - ARB_MODE=1: lowest requesting index wins and rr_ptr is unused. Starvation of high
//     indices is permitted.
//   Boundaries:
//   - mem_resp in IDLE or RESP is ignored.
//   - ch_* changes during BUSY do not affect mem_*.
//   - Index wrap-around uses NUM_CH-1 -> 0, including for NUM_CH that is not a power of 2.
//   - Only one ch_resp bit is ever set; ch_resp=0 outside RESP.
// TESTING
//   1 Read: ch0 read at 0x0000_0060 -> mem_read=1, mem_address=0x60 the next cycle.
//     mem_resp with rdata 0xDEADBEEF -> ch_resp=2'b01 and ch_rdata=0xDEADBEEF one cycle later.
//   2 Write: ch1 write at 0x100 with be=4'b0011, wdata=0x12345678 -> mem_write=1,
//     mem_byte_enable=0011, mem_wdata=0x12345678. ch_resp=2'b10 after mem_resp.
//   3 RR contention: ch0 and ch1 both request continuously for 4 transactions ->
//     grant order 0,1,0,1.
//     NUM_CH=3 with all requesting -> grant order 0,1,2,0.
//   4 ARB_MODE=1: ch0 re-requests continuously and ch1 is pending -> ch1 is never granted
//     while ch0 requests. Once ch0 drops, ch1 is granted.
//   5 Reset mid-BUSY: assert rst_n=0 while mem_read=1 -> all outputs 0 without waiting for
//     the clock. After release, a ch1-only request is granted; an ignored stale mem_resp does
//     not produce ch_resp.
//   6 Stability: ch0 changes its address during BUSY -> mem_address keeps the latched value.
//     A mem_resp pulse in IDLE -> no ch_resp, state stays IDLE.

Source files
------------

// File: rtl/mem_arbiter_rr_if.sv
// Bundle of the requester-side and memory-side handshake signals of mem_arbiter_rr.
// slave is the arbiter's view; master is the view of the requesters plus the memory.
interface mem_arbiter_rr_if #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned BE_W = DATA_W / 8;
  localparam int unsigned ID_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]        ch_read;
  logic [NUM_CH-1:0]        ch_write;
  logic [NUM_CH*ADDR_W-1:0] ch_address;
  logic [NUM_CH*DATA_W-1:0] ch_wdata;
  logic [NUM_CH*BE_W-1:0]   ch_byte_enable;
  logic [NUM_CH-1:0]        ch_resp;
  logic [DATA_W-1:0]        ch_rdata;
  logic                     mem_read;
  logic                     mem_write;
  logic [ADDR_W-1:0]        mem_address;
  logic [DATA_W-1:0]        mem_wdata;
  logic [BE_W-1:0]          mem_byte_enable;
  logic                     mem_resp;
  logic [DATA_W-1:0]        mem_rdata;
  logic                     busy;
  logic [ID_W-1:0]          grant_id;

  modport slave (
    input  ch_read, ch_write, ch_address, ch_wdata, ch_byte_enable, mem_resp, mem_rdata,
    output ch_resp, ch_rdata, mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
           busy, grant_id
  );

  modport master (
    output ch_read, ch_write, ch_address, ch_wdata, ch_byte_enable, mem_resp, mem_rdata,
    input  ch_resp, ch_rdata, mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
           busy, grant_id
  );
endinterface

// File: rtl/mem_arbiter_rr.sv
// N-channel arbiter (round-robin or fixed priority) merging requester ports onto one memory
// port; the granted request is latched so requesters cannot disturb an in-flight access.
module mem_arbiter_rr #(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ARB_MODE = 0
) (
  input logic            clk,
  input logic            rst_n,
  mem_arbiter_rr_if.slave bus
);
  localparam int unsigned BE_W = DATA_W / 8;
  localparam int unsigned ID_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   win;
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] resp_onehot;
  logic              any_req;
  logic              win_write;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic [BE_W-1:0]   win_be;

  always_comb begin
    int unsigned idx;
    logic        found;
    req     = bus.ch_read | bus.ch_write;
    any_req = |req;
    win     = '0;
    found   = 1'b0;
    idx     = 0;
    if (ARB_MODE == 0) begin
      // Search starts just after the last winner and wraps at NUM_CH, not at a power of two.
      for (int unsigned k = 1; k <= NUM_CH; k++) begin
        idx = 32'(rr_ptr) + k;
        if (idx >= NUM_CH) idx = idx - NUM_CH;
        if (!found && req[idx]) begin
          win   = ID_W'(idx);
          found = 1'b1;
        end
      end
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (!found && req[i]) begin
          win   = ID_W'(i);
          found = 1'b1;
        end
      end
    end
    win_write = bus.ch_write[win];
    win_addr  = bus.ch_address[32'(win)*ADDR_W +: ADDR_W];
    win_wdata = bus.ch_wdata[32'(win)*DATA_W +: DATA_W];
    win_be    = bus.ch_byte_enable[32'(win)*BE_W +: BE_W];
    resp_onehot = '0;
    resp_onehot[bus.grant_id] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= IDLE;
      rr_ptr              <= ID_W'(NUM_CH - 1);
      bus.grant_id        <= '0;
      bus.busy            <= 1'b0;
      bus.mem_read        <= 1'b0;
      bus.mem_write       <= 1'b0;
      bus.mem_address     <= '0;
      bus.mem_wdata       <= '0;
      bus.mem_byte_enable <= '0;
      bus.ch_resp         <= '0;
      bus.ch_rdata        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            bus.mem_address     <= win_addr;
            bus.mem_wdata       <= win_wdata;
            bus.mem_read        <= ~win_write;
            bus.mem_write       <= win_write;
            bus.mem_byte_enable <= win_write ? win_be : '0;
            bus.grant_id        <= win;
            bus.busy            <= 1'b1;
            if (ARB_MODE == 0) rr_ptr <= win;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (bus.mem_resp) begin
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
            bus.ch_rdata  <= bus.mem_rdata;
            bus.ch_resp   <= resp_onehot;
            state         <= RESP;
          end
        end
        RESP: begin
          bus.ch_resp <= '0;
          bus.busy    <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
